// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared line-interface types for the memory arbiter and dcache
package mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [LINE_W_DEF-1:0] data;
  } line_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way winner select, fixed priority or round-robin on a last-grant pointer
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic any,
  output logic win
);

  always_comb begin
    any = req0 | req1;
    win = req1;
    if (req0 && req1) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises two line requesters onto one Data_Memory port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [LINE_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [LINE_W-1:0] req1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              err_o,
  output logic [CNT_W-1:0]  grant_cnt0_o,
  output logic [CNT_W-1:0]  grant_cnt1_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } arb_req_t;

  arb_state_e        state, state_nxt;
  arb_req_t          lat_req;
  logic              gnt;
  logic              last_gnt;
  logic [WD_W-1:0]   wdog;
  logic [LINE_W-1:0] cap_data;
  logic              err;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              any_req, win, grant_go, wd_expired;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr_arb2 (
    .req0    (req0_enable_i),
    .req1    (req1_enable_i),
    .last_gnt(last_gnt),
    .any     (any_req),
    .win     (win)
  );

  assign wd_expired = (wdog == WD_LAST);

  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_BUSY;
          grant_go  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i || wd_expired) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      lat_req  <= '0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      wdog     <= '0;
      cap_data <= '0;
      err      <= 1'b0;
      cnt0     <= '0;
      cnt1     <= '0;
    end else begin
      state <= state_nxt;
      if (grant_go) begin
        gnt      <= win;
        last_gnt <= win;
        wdog     <= '0;
        if (win) begin
          lat_req <= '{write: req1_write_i, addr: req1_addr_i, data: req1_data_i};
          if (cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end else begin
          lat_req <= '{write: req0_write_i, addr: req0_addr_i, data: req0_data_i};
          if (cnt0 != '1) cnt0 <= cnt0 + 1'b1;
        end
      end
      if (state == ST_BUSY) begin
        wdog <= wdog + 1'b1;
        // A real ack wins over a watchdog expiry landing on the same cycle.
        if (mem_ack_i) begin
          cap_data <= mem_data_i;
        end else if (wd_expired) begin
          cap_data <= '0;
          err      <= 1'b1;
        end
      end
    end
  end

  assign mem_enable_o = (state == ST_BUSY);
  assign mem_write_o  = lat_req.write;
  assign mem_addr_o   = lat_req.addr;
  assign mem_data_o   = lat_req.data;
  assign req0_ack_o   = (state == ST_RESP) && !gnt;
  assign req1_ack_o   = (state == ST_RESP) && gnt;
  assign req0_data_o  = cap_data;
  assign req1_data_o  = cap_data;
  assign err_o        = err;
  assign grant_cnt0_o = cnt0;
  assign grant_cnt1_o = cnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         r0_en = 1'b0, r0_wr = 1'b0, r1_en = 1'b0, r1_wr = 1'b0;
  logic [31:0]  r0_addr = '0, r1_addr = '0;
  logic [255:0] r0_data = '0, r1_data = '0;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;

  logic         ack0, ack1, m_en, m_wr, err;
  logic [255:0] d0, d1, m_wdata;
  logic [31:0]  m_addr;
  logic [15:0]  cnt0, cnt1;

  logic         f_ack0, f_ack1, f_en, f_wr, f_err;
  logic [255:0] f_d0, f_d1, f_wdata;
  logic [31:0]  f_addr;
  logic [15:0]  f_cnt0, f_cnt1;

  int n_err = 0;
  int n_chk = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(r0_en), .req0_write_i(r0_wr), .req0_addr_i(r0_addr), .req0_data_i(r0_data),
    .req0_ack_o(ack0), .req0_data_o(d0),
    .req1_enable_i(r1_en), .req1_write_i(r1_wr), .req1_addr_i(r1_addr), .req1_data_i(r1_data),
    .req1_ack_o(ack1), .req1_data_o(d1),
    .mem_enable_o(m_en), .mem_write_o(m_wr), .mem_addr_o(m_addr), .mem_data_o(m_wdata),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .err_o(err), .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1)
  );

  mem_arbiter #(.FIXED_PRIO(1)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(r0_en), .req0_write_i(r0_wr), .req0_addr_i(r0_addr), .req0_data_i(r0_data),
    .req0_ack_o(f_ack0), .req0_data_o(f_d0),
    .req1_enable_i(r1_en), .req1_write_i(r1_wr), .req1_addr_i(r1_addr), .req1_data_i(r1_data),
    .req1_ack_o(f_ack1), .req1_data_o(f_d1),
    .mem_enable_o(f_en), .mem_write_o(f_wr), .mem_addr_o(f_addr), .mem_data_o(f_wdata),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .err_o(f_err), .grant_cnt0_o(f_cnt0), .grant_cnt1_o(f_cnt1)
  );

  typedef struct {
    int           port;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           lat;
    logic [255:0] rdata;
    logic [255:0] exp_data;
  } txn_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnts(input string name);
    chk({name, " cnt0"}, 256'(cnt0), 256'(exp_cnt0));
    chk({name, " cnt1"}, 256'(cnt1), 256'(exp_cnt1));
  endtask

  task automatic run_txn(input txn_t t, input string nm);
    logic ok;
    if (t.port == 0) begin
      r0_en = 1'b1; r0_wr = t.wr; r0_addr = t.addr; r0_data = t.wdata;
    end else begin
      r1_en = 1'b1; r1_wr = t.wr; r1_addr = t.addr; r1_data = t.wdata;
    end
    tick();
    ok = 1'b1;
    for (int i = 1; i <= t.lat; i++) begin
      if (m_en !== 1'b1 || m_wr !== t.wr || m_addr !== t.addr || m_wdata !== t.wdata ||
          ack0 !== 1'b0 || ack1 !== 1'b0) ok = 1'b0;
      if (i == t.lat) begin
        mem_ack = 1'b1;
        mem_rdata = t.rdata;
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk({nm, " busy phase"}, 256'(ok), 256'(1));
    chk({nm, " acks"}, 256'({ack1, ack0}), (t.port == 0) ? 256'(2'b01) : 256'(2'b10));
    chk({nm, " rdata"}, (t.port == 0) ? d0 : d1, t.exp_data);
    chk({nm, " enable in resp"}, 256'(m_en), 256'(0));
    r0_en = 1'b0;
    r1_en = 1'b0;
    tick();
    chk({nm, " ack after resp"}, 256'({ack1, ack0}), 256'(0));
    if (t.port == 0) exp_cnt0++; else exp_cnt1++;
    chk_cnts(nm);
  endtask

  initial begin
    txn_t tbl[4];
    txn_t t;
    int   order_rr[$];
    int   order_fx[$];
    int   busy;
    logic ok;
    logic [255:0] ecfa;
    logic [255:0] pat;

    pat  = {8{32'hA5A5_0F0F}};
    ecfa = {16{16'hECFA}};
    tbl[0] = '{port: 0, wr: 1'b0, addr: 32'h0,   wdata: 256'h0,      lat: 10, rdata: 256'd5,   exp_data: 256'd5};
    tbl[1] = '{port: 1, wr: 1'b0, addr: 32'h80,  wdata: 256'h0,      lat: 1,  rdata: pat,      exp_data: pat};
    tbl[2] = '{port: 0, wr: 1'b1, addr: 32'h40,  wdata: 256'h1234,   lat: 3,  rdata: 256'h77,  exp_data: 256'h77};
    tbl[3] = '{port: 1, wr: 1'b1, addr: 32'hFC0, wdata: ~256'h0,     lat: 2,  rdata: 256'h0,   exp_data: 256'h0};

    // reset state
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("reset acks", 256'({ack1, ack0}), 256'(0));
    chk("reset mem_enable", 256'(m_en), 256'(0));
    chk("reset mem_write", 256'(m_wr), 256'(0));
    chk("reset mem_addr", 256'(m_addr), 256'(0));
    chk("reset mem_data", m_wdata, 256'(0));
    chk("reset rdata", d0, 256'(0));
    chk("reset err", 256'(err), 256'(0));
    chk_cnts("reset");

    for (int i = 0; i < 4; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // contention: pointer is 1 after vec3, so round-robin starts with port 0
    r0_en = 1'b1; r0_wr = 1'b0; r0_addr = 32'h100;
    r1_en = 1'b1; r1_wr = 1'b0; r1_addr = 32'h200;
    mem_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack0) order_rr.push_back(0);
      if (ack1) order_rr.push_back(1);
      if (f_ack0) order_fx.push_back(0);
      if (f_ack1) order_fx.push_back(1);
    end
    r0_en = 1'b0;
    r1_en = 1'b0;
    mem_ack = 1'b0;
    chk("rr grant count", 256'(order_rr.size()), 256'(4));
    chk("fix grant count", 256'(order_fx.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr order[%0d]", i), (i < order_rr.size()) ? 256'(order_rr[i]) : 256'(9), 256'(i % 2));
      chk($sformatf("fix order[%0d]", i), (i < order_fx.size()) ? 256'(order_fx[i]) : 256'(9), 256'(0));
    end
    exp_cnt0 += 2;
    exp_cnt1 += 2;
    tick();
    chk_cnts("contention");

    // write pass-through with requester inputs changing mid-BUSY
    r1_en = 1'b1; r1_wr = 1'b1; r1_addr = 32'h40; r1_data = ecfa;
    tick();
    ok = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (m_en !== 1'b1 || m_wr !== 1'b1 || m_addr !== 32'h40 || m_wdata !== ecfa) ok = 1'b0;
      if (i == 2) begin
        r1_data = ~ecfa; r1_addr = 32'h999; r1_wr = 1'b0;
      end
      if (i == 6) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    r1_en = 1'b0;
    chk("wr passthrough stable", 256'(ok), 256'(1));
    chk("wr passthrough ack1", 256'({ack1, ack0}), 256'(2'b10));
    tick();
    exp_cnt1++;
    chk_cnts("wr passthrough");

    // spurious ack in IDLE
    mem_ack = 1'b1;
    mem_rdata = 256'hDEAD;
    tick();
    mem_ack = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || m_en !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("spurious ack quiet", 256'(ok), 256'(1));
    chk_cnts("spurious ack");

    // watchdog timeout
    mem_rdata = 256'hBEEF;
    r0_en = 1'b1; r0_wr = 1'b0; r0_addr = 32'h300;
    tick();
    chk("timeout err before", 256'(err), 256'(0));
    busy = 0;
    for (int i = 0; i < 100 && !ack0; i++) begin
      if (m_en) busy++;
      tick();
    end
    r0_en = 1'b0;
    chk("timeout busy cycles", 256'(busy), 256'(64));
    chk("timeout ack0", 256'(ack0), 256'(1));
    chk("timeout rdata", d0, 256'(0));
    chk("timeout err", 256'(err), 256'(1));
    tick();
    exp_cnt0++;
    t = '{port: 1, wr: 1'b0, addr: 32'h500, wdata: 256'h0, lat: 2, rdata: 256'h42, exp_data: 256'h42};
    run_txn(t, "post-timeout");
    chk("err sticky", 256'(err), 256'(1));

    // reset in the fifth BUSY cycle
    r1_en = 1'b1; r1_wr = 1'b1; r1_addr = 32'h600; r1_data = pat;
    tick();
    for (int i = 1; i < 5; i++) tick();
    chk("pre-reset enable", 256'(m_en), 256'(1));
    rst = 1'b0;
    r1_en = 1'b0;
    tick();
    rst = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    chk("rst busy enable", 256'(m_en), 256'(0));
    chk("rst busy write", 256'(m_wr), 256'(0));
    chk("rst busy addr", 256'(m_addr), 256'(0));
    chk("rst busy wdata", m_wdata, 256'(0));
    chk("rst busy rdata", d1, 256'(0));
    chk("rst busy err", 256'(err), 256'(0));
    chk_cnts("rst busy");
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ack0 !== 1'b0 || ack1 !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("rst busy no ack", 256'(ok), 256'(1));

    // pointer back at 1: first tie after reset goes to port 0
    r0_en = 1'b1; r1_en = 1'b1; mem_ack = 1'b1;
    tick();
    tick();
    chk("post-reset tie", 256'({ack1, ack0}), 256'(2'b01));
    r0_en = 1'b0; r1_en = 1'b0; mem_ack = 1'b0;
    tick();
    exp_cnt0++;
    t = '{port: 1, wr: 1'b0, addr: 32'h700, wdata: 256'h0, lat: 4, rdata: pat, exp_data: pat};
    run_txn(t, "post-reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single off-chip `Data_Memory` line interface between the data cache (port 0) and a second line requester (port 1: instruction cache or DMA). It sits between the cache controllers and `Data_Memory`. It serialises 256-bit line reads and writes, one outstanding transaction at a time. Arbitration is round-robin by default, and a watchdog turns a missing memory ack into an error response instead of a hang.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `LINE_W`, 256: line data width.
- `FIXED_PRIO`, 0: 1 makes port 0 always win simultaneous requests; 0 selects round-robin.
- `TIMEOUT`, 64: BUSY cycles without `mem_ack_i` before an error response.
- `CNT_W`, 16: width of the per-port grant counters.

Ports (`p` ∈ {0,1}):
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `req{p}_enable_i`  in  1  request valid; held until ack.
- `req{p}_write_i`  in  1  1 = line write, 0 = line read.
- `req{p}_addr_i`  in  ADDR_W  line address.
- `req{p}_data_i`  in  LINE_W  write data.
- `req{p}_ack_o`  out  1  one-cycle completion pulse.
- `req{p}_data_o`  out  LINE_W  read data; valid while ack is high.
- `mem_enable_o`  out  1  to Data_Memory `enable_i`.
- `mem_write_o`  out  1  to Data_Memory `write_i`.
- `mem_addr_o`  out  ADDR_W  to Data_Memory `addr_i`.
- `mem_data_o`  out  LINE_W  to Data_Memory `data_i`.
- `mem_ack_i`  in  1  from Data_Memory `ack_o`.
- `mem_data_i`  in  LINE_W  from Data_Memory `data_o`.
- `err_o`  out  1  sticky timeout flag.
- `grant_cnt0_o`, `grant_cnt1_o`  out  CNT_W  saturating grant counts.

## Operation

- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:** if any `req{p}_enable_i` is high, select a winner and latch its write, addr and data into the memory-side registers. Record the winner in `gnt`, increment its grant counter (saturate at all-ones), and go to BUSY.
- **Winner selection:**
  - Single requester: that port wins.
  - Both requesting, `FIXED_PRIO`=1: port 0 wins.
  - Both requesting, `FIXED_PRIO`=0: the port not granted last wins. The last-grant pointer resets to 1, so port 0 wins the first tie.
- **BUSY:**
  - `mem_enable_o`=1; `mem_write_o`, `mem_addr_o` and `mem_data_o` come from the latched registers and are stable for the whole state.
  - Watchdog counts up from 0.
  - On `mem_ack_i`=1: capture `mem_data_i`, go to RESP.
  - On watchdog = TIMEOUT−1 without ack: set `err_o`, capture zero data, go to RESP.
- **RESP:**
  - `mem_enable_o`=0.
  - `req{gnt}_ack_o`=1 and `req{gnt}_data_o` = captured data for exactly one cycle.
  - The non-granted port's ack stays 0.
  - Always returns to IDLE.
- **Requester obligation:** the requester deasserts enable on the edge where it samples ack, so the following IDLE cycle does not re-grant the same transaction.
- **Ignored inputs:** `mem_ack_i` is ignored in IDLE and RESP. Requester inputs that change during BUSY are ignored, because the latched copy drives memory.
- **Data outputs:** `req{p}_data_o` holds its last value when ack is low. Both ports share one capture register.

## Timing

- **Reset values (`rst_i`=0 at a rising edge):**
  - state=IDLE, all acks 0, `mem_enable_o`=0, `mem_write_o`=0.
  - `mem_addr_o`, `mem_data_o` and the captured data = 0.
  - `err_o`=0, counters=0, watchdog=0, last-grant pointer=1.
- **Reset mid-transaction:** aborts BUSY or RESP with no ack issued. `mem_enable_o` drops on the reset edge.
- **Latency:**
  - Request seen in IDLE at cycle 0.
  - `mem_enable_o` high from cycle 1.
  - `mem_ack_i` at cycle k gives requester ack at cycle k+1.
  - Earliest next grant is at cycle k+2.
- **Back-to-back:** minimum 3 cycles per transaction (IDLE, BUSY, RESP) with a 1-cycle memory.
- **Memory enable:** `mem_enable_o` is low for at least one cycle between transactions.
- **Outputs:** all are registered or decoded from state only. There is no combinational path from `req*` or `mem_ack_i` to any output.

## Structure

- **Package `mem_pkg`:** the state enum (IDLE/BUSY/RESP), the `LINE_W` and `ADDR_W` defaults, and a line-request struct (write, addr, data). The same package is shared with `dcache`.
- **Sub-module `rr_arb2`:** combinational two-way winner selection with `FIXED_PRIO` and the last-grant pointer input.
- **Top level:** the FSM, watchdog, capture registers and counters stay in the top module.

## Test plan

- **Single read:** port 0 reads addr 0x0, memory acks after 10 cycles with data 5 → `mem_enable_o` high cycles 1–10, `req0_ack_o` pulse at cycle 11 with data 5, `grant_cnt0_o`=1.
- **Contention:** both ports request continuously for 4 transactions → grant order 0,1,0,1 in round-robin mode; 0,0,0,0 with `FIXED_PRIO`=1.
- **Write pass-through:** port 1 writes 0xECFA… to 0x40 while changing `req1_data_i` mid-BUSY → `mem_data_o` stays 0xECFA… throughout; `mem_write_o`=1.
- **Timeout:** no `mem_ack_i` with `TIMEOUT`=64 → RESP after 64 BUSY cycles, ack with data 0, `err_o`=1 and sticky until reset.
- **Reset mid-BUSY:** `rst_i`=0 at cycle 5 of BUSY → no ack ever issued, `mem_enable_o`=0 after the edge, all outputs at reset values; the next request is served normally.
- **Spurious ack:** `mem_ack_i` pulsed in IDLE → no requester ack and no state change.
